gcd_datapath: RTL



---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_alu.sv | 32 +++
 rtl/gcd_datapath.sv | 110 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared GCD definitions: opcode encodings and the default datapath width,
// used by both the datapath and the control unit.
package gcd_pkg;

    localparam int unsigned GCD_W  = 8;
    localparam int unsigned S_BITS = 4;

    typedef logic [S_BITS-1:0] opcode_t;

    localparam opcode_t S_NEQ = 4'b1111;
    localparam opcode_t S_LT  = 4'b1110;
    localparam opcode_t S_SUB = 4'b0010;
    localparam opcode_t S_NOP = 4'b0000;

endpackage

// File: rtl/gcd_alu.sv
// Combinational compare / absolute-difference unit of the GCD datapath.
// With GCD_DP_ZERO_CHK_EN, NEQ reports "equal" when either operand is zero.
module gcd_alu
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  logic [S_BITS-1:0] s,
    input  logic [W-1:0]      x,
    input  logic [W-1:0]      y,
    output logic              d,
    output logic [W-1:0]      alu
);

    always_comb begin
        d   = 1'b0;
        alu = '0;
        case (s)
            S_NEQ:   d   = (x != y);
            S_LT:    d   = (x < y);
            S_SUB:   alu = (x >= y) ? W'(x - y) : W'(y - x);
            default: ;
        endcase
`ifdef GCD_DP_ZERO_CHK_EN
        // A zero operand would never converge; force termination instead.
        if ((s == S_NEQ) && ((x == '0) || (y == '0))) begin
            d = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand buffer, working registers X/Y, result register with
// valid/ready output. Optional zero-operand check via GCD_DP_ZERO_CHK_EN.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_x,
    input  logic [W-1:0]      in_y,
    output logic              go,
    input  logic              Xs,
    input  logic              Ys,
    input  logic              Xld,
    input  logic              Yld,
    input  logic              Dld,
    input  logic [S_BITS-1:0] S,
    output logic              D,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res,
    output logic              err
);

    logic [W-1:0] x_q, y_q;
    logic [W-1:0] buf_x, buf_y;
    logic         buf_full;
    logic [W-1:0] r_q;
    logic         res_valid_q;
    logic         err_q;
    logic [W-1:0] alu;

    logic         capture;
    logic         consume;
    logic         res_hs;
    logic [W-1:0] r_next;
    logic         err_next;

    gcd_alu #(.W(W)) u_alu (
        .s   (S),
        .x   (x_q),
        .y   (y_q),
        .d   (D),
        .alu (alu)
    );

    assign in_ready  = rst_n & ~buf_full;
    assign go        = buf_full;
    assign res_valid = res_valid_q;
    assign res       = r_q;
    assign err       = err_q;

    assign capture = in_valid & in_ready;
    assign consume = Xld & ~Xs & Yld & ~Ys;
    assign res_hs  = res_valid_q & res_ready;

    // Value and error flag captured into the result register on Dld.
    always_comb begin
        r_next   = x_q;
        err_next = 1'b0;
`ifdef GCD_DP_ZERO_CHK_EN
        if ((x_q == '0) || (y_q == '0)) begin
            r_next   = (x_q >= y_q) ? x_q : y_q;
            err_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            buf_x       <= '0;
            buf_y       <= '0;
            buf_full    <= 1'b0;
            r_q         <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (Xld) begin
                x_q <= Xs ? alu : buf_x;
            end
            if (Yld) begin
                y_q <= Ys ? alu : buf_y;
            end

            if (capture) begin
                buf_x    <= in_x;
                buf_y    <= in_y;
                buf_full <= 1'b1;
            end else if (consume) begin
                buf_full <= 1'b0;
            end

            // A new result takes priority over a coincident handshake.
            if (Dld) begin
                r_q         <= r_next;
                res_valid_q <= 1'b1;
                err_q       <= err_next;
            end else if (res_hs) begin
                res_valid_q <= 1'b0;
                err_q       <= 1'b0;
            end
        end
    end

endmodule
